// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer for one MAC: issues paired operand reads, clears then enables
// the MAC for len terms, captures the 8-bit MAC output and pulses done.
module mac_seq_ctrl #(
  parameter int ADDR_W = 4,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [ADDR_W-1:0] base1,
  input  logic [ADDR_W-1:0] base2,
  output logic [ADDR_W-1:0] addr1,
  output logic [ADDR_W-1:0] addr2,
  output logic              mac_active,
  output logic              mac_clear,
  input  logic [7:0]        mac_val,
  output logic [7:0]        result,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            state;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  k;
  logic [ADDR_W-1:0] base1_q;
  logic [ADDR_W-1:0] base2_q;
  logic [ADDR_W-1:0] off;
  logic              last_term;

  assign last_term = (k == len_q - LEN_W'(1));

  // RUN cycle k prefetches term k+1; CLEAR (and all other states) present offset 0.
  assign off   = (state == S_RUN) ? ADDR_W'(k + LEN_W'(1)) : '0;
  assign addr1 = base1_q + off;
  assign addr2 = base2_q + off;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      len_q      <= '0;
      k          <= '0;
      base1_q    <= '0;
      base2_q    <= '0;
      result     <= '0;
      mac_active <= 1'b0;
      mac_clear  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            len_q     <= len;
            base1_q   <= base1;
            base2_q   <= base2;
            k         <= '0;
            mac_clear <= 1'b1;
            busy      <= 1'b1;
            state     <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          mac_clear <= 1'b0;
          if (len_q == '0) begin
            state <= S_WAIT;
          end else begin
            mac_active <= 1'b1;
            state      <= S_RUN;
          end
        end
        S_RUN: begin
          k <= k + LEN_W'(1);
          if (last_term) begin
            mac_active <= 1'b0;
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          // mac_val has absorbed the final term by now.
          result <= mac_val;
          done   <= 1'b1;
          state  <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          mac_active <= 1'b0;
          mac_clear  <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl with a behavioural operand-buffer + MAC environment.
module tb_mac_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] len;
  logic [3:0] base1, base2, addr1, addr2;
  logic       mac_active, mac_clear, busy, done;
  logic [7:0] mac_val, result;

  int total = 0;
  int bad   = 0;

  mac_seq_ctrl #(.ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .base1(base1), .base2(base2), .addr1(addr1), .addr2(addr2),
    .mac_active(mac_active), .mac_clear(mac_clear), .mac_val(mac_val),
    .result(result), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Operand buffers (1-cycle read) and a MAC accumulating the product's upper byte.
  logic [7:0]  buf1 [16];
  logic [7:0]  buf2 [16];
  logic [7:0]  rd1 = 8'h00, rd2 = 8'h00;
  logic [11:0] acc = 12'h000;
  logic [15:0] prod;
  assign prod    = rd1 * rd2;
  assign mac_val = acc[11:4];

  always @(posedge clk) begin
    rd1 <= buf1[addr1];
    rd2 <= buf2[addr2];
    if (mac_clear)       acc <= 12'h000;
    else if (mac_active) acc <= acc + {4'h0, prod[15:8]};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill(input logic [7:0] v1, input logic [7:0] v2);
    for (int i = 0; i < 16; i++) begin
      buf1[i] = v1;
      buf2[i] = v2;
    end
  endtask

  // Launch one job from IDLE and observe it to completion; mid>0 re-pulses start at that cycle.
  task automatic run_job(input int l, input int b1, input int b2, input int mid,
                         input logic [7:0] exp_res, input string nm);
    int c, nclr, nact, doff, both;
    logic seen;
    logic [3:0] a1 [17];
    logic [3:0] a2 [17];
    for (int i = 0; i < 17; i++) begin
      a1[i] = 'x;
      a2[i] = 'x;
    end
    c = 0; nclr = 0; nact = 0; doff = -1; both = 0; seen = 1'b0;
    @(negedge clk);
    len = 5'(l); base1 = 4'(b1); base2 = 4'(b2); start = 1'b1;
    while (!seen && c < 60) begin
      @(negedge clk);
      c++;
      start = 1'b0;
      if (mac_clear && mac_active) both++;
      if (mac_clear) begin
        a1[0] = addr1; a2[0] = addr2; nclr++;
      end
      if (mac_active) begin
        if (nact < 16) begin
          a1[nact+1] = addr1; a2[nact+1] = addr2;
        end
        nact++;
      end
      if (done) begin
        seen = 1'b1; doff = c - 1;
      end
      if (c == mid) begin
        start = 1'b1; len = 5'd2; base1 = 4'd9; base2 = 4'd9;
      end
    end
    check({nm, "_done_seen"}, 32'(seen), 32'd1);
    check({nm, "_clear_cycles"}, 32'(nclr), 32'd1);
    check({nm, "_active_cycles"}, 32'(nact), 32'(l));
    check({nm, "_done_latency"}, 32'(doff), 32'(l + 2));
    check({nm, "_clear_and_active"}, 32'(both), 32'd0);
    check({nm, "_result"}, 32'(result), 32'(exp_res));
    for (int i = 0; i <= l; i++) begin
      check($sformatf("%s_addr1_%0d", nm, i), 32'(a1[i]), 32'((b1 + i) % 16));
      check($sformatf("%s_addr2_%0d", nm, i), 32'(a2[i]), 32'((b2 + i) % 16));
    end
  endtask

  initial begin
    int nclr, ndone;
    logic busy7, busy14, clr8;

    rst = 1'b1; start = 1'b0; len = '0; base1 = '0; base2 = '0;
    fill(8'h80, 8'h80);
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'h00);
    check("rst_addr1", 32'(addr1), 32'd0);
    rst = 1'b0;

    // 4 x (0x80*0x80)>>8 = 0x100 -> 0x10
    run_job(4, 0, 4, 0, 8'h10, "basic");

    // Abort mid-RUN of a len=8 job
    @(negedge clk);
    len = 5'd8; base1 = 4'd0; base2 = 4'd0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midrun_busy", 32'(busy), 32'd1);
    check("midrun_active", 32'(mac_active), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_active", 32'(mac_active), 32'd0);
    check("abort_clear", 32'(mac_clear), 32'd0);
    check("abort_result", 32'(result), 32'h00);
    check("abort_addr2", 32'(addr2), 32'd0);

    // MAC still holds a partial sum; CLEAR must discard it: 0x40 -> 0x04
    run_job(1, 0, 0, 0, 8'h04, "after_abort");

    run_job(0, 3, 7, 0, 8'h00, "zero_len");

    // Wrap: 0xF0*0xFF, 0xE0*0x0F, 0xD0*0x1F, 0xC0*0x2F -> EF+0D+19+23 = 0x138 -> 0x13
    fill(8'h00, 8'h00);
    for (int i = 0; i < 16; i++) buf2[i] = 8'(16 * i + 15);
    buf1[14] = 8'hF0; buf1[15] = 8'hE0; buf1[0] = 8'hD0; buf1[1] = 8'hC0;
    run_job(4, 14, 15, 0, 8'h13, "wrap");

    // start held high through a len=3 run: period 7 cycles, one IDLE cycle between runs
    fill(8'h80, 8'h80);
    @(negedge clk);
    len = 5'd3; base1 = 4'd0; base2 = 4'd0; start = 1'b1;
    nclr = 0; ndone = 0; busy7 = 1'b1; busy14 = 1'b1; clr8 = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (mac_clear) nclr++;
      if (done) ndone++;
      if (c == 7)  busy7 = busy;
      if (c == 8)  clr8 = mac_clear;
      if (c == 14) busy14 = busy;
    end
    start = 1'b0;
    check("held_clears", 32'(nclr), 32'd2);
    check("held_dones", 32'(ndone), 32'd2);
    check("held_idle_gap", 32'(busy7), 32'd0);
    check("held_rerun_clear", 32'(clr8), 32'd1);
    check("held_second_idle", 32'(busy14), 32'd0);
    check("held_result", 32'(result), 32'h0C);

    // Stray start mid-RUN with different len/bases must be ignored: 8 x 0x40 -> 0x20
    run_job(8, 0, 0, 3, 8'h20, "midstart");

    // Full buffer: 16 x 0xFE = 0xFE0 -> 0xFE
    fill(8'hFF, 8'hFF);
    run_job(16, 0, 0, 0, 8'hFE, "full");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("hold_result_%0d", i), 32'(result), 32'hFE);
      check($sformatf("hold_busy_%0d", i), 32'(busy), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
